// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared encodings and request checking for the load/store unit
package mem_lsu_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;
    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_MISAL = 2'b01;
    localparam logic [1:0] ERR_FAULT = 2'b10;
    localparam logic [1:0] ERR_SIZE  = 2'b11;
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;
    localparam logic [1:0] ST_RESP  = 2'b11;
    typedef logic [1:0] state_t;
    function automatic logic [1:0] chk_req(input logic [1:0] size, input logic [31:0] addr,
                                           input int unsigned mem_size);
        return size == SZ_X ? ERR_SIZE :
               ((size == SZ_H && addr[0]) || (size == SZ_W && addr[1:0] != 2'b00)) ? ERR_MISAL :
               ({2'b00, addr[31:2]} >= mem_size) ? ERR_FAULT : ERR_OK;
    endfunction
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: core request/response and memory port bundle of the load/store unit
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd_strobe;
    logic [3:0]  mem_wr_strobe;
    logic [31:0] mem_rdata;
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_rd_strobe, mem_wr_strobe
    );
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_rd_strobe, mem_wr_strobe
    );
endinterface

// File: rtl/mem_lsu_align.sv
// lsu_align: store lane mask/replication and load lane extract with sign/zero extension
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [31:0] sh;
    always_comb begin
        sh      = rdata_i >> {off_i, 3'b000};
        wmask_o = size_i == SZ_B ? 4'b0001 << off_i : size_i == SZ_H ? 4'b0011 << off_i : 4'b1111;
        wdata_o = size_i == SZ_B ? {4{wdata_i[7:0]}} : size_i == SZ_H ? {2{wdata_i[15:0]}} : wdata_i;
        rdata_o = size_i == SZ_B ? {{24{~uns_i & sh[7]}}, sh[7:0]} :
                  size_i == SZ_H ? {{16{~uns_i & sh[15]}}, sh[15:0]} : sh;
    end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store initiator with alignment/range checks
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 1024
) (
    input logic clk,
    input logic rst,
    mem_lsu_if.slave bus
);
    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d, off_q, off_d, err_q, err_d, req_err;
    logic        uns_q, uns_d, we_q, we_d, vld_q, vld_d, rd_q, rd_d, idle, acc;
    logic [3:0]  wr_q, wr_d, al_mask;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, al_wdata, al_rdata;

    assign idle    = state_q == ST_IDLE;
    assign acc     = idle && bus.req_valid;
    assign req_err = chk_req(bus.req_size, bus.req_addr, MEM_SIZE);

    // Store lanes come from the live request at acceptance; load extraction uses latched fields in WAIT.
    lsu_align u_align (
        .size_i (idle ? bus.req_size : size_q),
        .uns_i  (uns_q),
        .off_i  (idle ? bus.req_addr[1:0] : off_q),
        .wdata_i(bus.req_wdata),
        .rdata_i(bus.mem_rdata),
        .wmask_o(al_mask),
        .wdata_o(al_wdata),
        .rdata_o(al_rdata)
    );

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        vld_d   = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 4'b0000;
        if (acc && req_err != ERR_OK) begin
            state_d = ST_RESP;
            vld_d   = 1'b1;
            rdata_d = '0;
            err_d   = req_err;
        end else if (acc) begin
            state_d = ST_ISSUE;
            size_d  = bus.req_size;
            uns_d   = bus.req_unsigned;
            off_d   = bus.req_addr[1:0];
            we_d    = bus.req_we;
            addr_d  = {bus.req_addr[31:2], 2'b00};
            wdata_d = al_wdata;
            rd_d    = ~bus.req_we;
            wr_d    = bus.req_we ? al_mask : 4'b0000;
        end else if (state_q == ST_ISSUE) begin
            state_d = we_q ? ST_RESP : ST_WAIT;
            vld_d   = we_q;
            rdata_d = we_q ? '0 : rdata_q;
            err_d   = we_q ? ERR_OK : err_q;
        end else if (state_q == ST_WAIT) begin
            state_d = ST_RESP;
            vld_d   = 1'b1;
            rdata_d = al_rdata;
            err_d   = ERR_OK;
        end else if (state_q == ST_RESP) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= '0;
            vld_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign bus.req_ready     = idle;
    assign bus.rsp_valid     = vld_q;
    assign bus.rsp_rdata     = rdata_q;
    assign bus.rsp_err       = err_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_rd_strobe = rd_q;
    assign bus.mem_wr_strobe = wr_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: vector table plus response scoreboard for mem_lsu
module tb_mem_lsu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] mrd_src = '0;
    logic [31:0] mem_q = '0;

    mem_lsu_if bus ();
    mem_lsu #(.MEM_SIZE(1024)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Registered memory: data requested in one cycle appears in the next.
    always @(posedge clk) mem_q <= bus.mem_rd_strobe ? mrd_src : 32'h5A5A5A5A;
    assign bus.mem_rdata = mem_q;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic [31:0] x_addr;
        logic [3:0]  x_mask;
        logic [31:0] x_wdata;
        logic [31:0] x_rdata;
        logic [1:0]  x_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_err", {30'd0, bus.rsp_err}, {30'd0, e.err});
                chk("rsp_latency", cyc - e.acc, e.lat);
            end
        end
        if (bus.mem_rd_strobe === 1'b1 && bus.mem_wr_strobe !== 4'b0000)
            chk("rd_wr_both", 32'd1, 32'd0);
    end

    task automatic issue(input vec_t v);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", {31'd0, bus.req_ready}, 32'd1);
        bus.req_we       = v.we;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        bus.req_valid    = 1'b1;
        mrd_src          = v.mrd;
        e.rdata = v.x_rdata;
        e.err   = v.x_err;
        e.acc   = cyc;
        e.lat   = v.x_err != 2'b00 ? 1 : v.we ? 2 : 3;
        sb.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_size  = 2'($urandom_range(0, 3));
        bus.req_we    = 1'($urandom_range(0, 1));
        chk("issue_rd", {31'd0, bus.mem_rd_strobe}, {31'd0, v.x_err == 2'b00 && !v.we});
        chk("issue_wr", {28'd0, bus.mem_wr_strobe}, {28'd0, (v.x_err == 2'b00 && v.we) ? v.x_mask : 4'b0000});
        if (v.x_err == 2'b00) chk("mem_addr", bus.mem_addr, v.x_addr);
        if (v.x_err == 2'b00 && v.we) chk("mem_wdata", bus.mem_wdata, v.x_wdata);
        @(negedge clk);
        chk("post_strobes", {27'd0, bus.mem_rd_strobe, bus.mem_wr_strobe}, 32'd0);
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0;
        //          we    sz     u     addr          wdata         mrd           x_addr        mask     x_wdata       x_rdata       err
        vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h00000010, 32'hDEADBEEF, 32'h0,        32'h00000010, 4'b1111, 32'hDEADBEEF, 32'h00000000, 2'b00};
        vt[1]  = '{1'b0, 2'b00, 1'b0, 32'h00000013, 32'h0,        32'h80FF1234, 32'h00000010, 4'b0000, 32'h0,        32'hFFFFFF80, 2'b00};
        vt[2]  = '{1'b0, 2'b00, 1'b1, 32'h00000013, 32'h0,        32'h80FF1234, 32'h00000010, 4'b0000, 32'h0,        32'h00000080, 2'b00};
        vt[3]  = '{1'b1, 2'b01, 1'b0, 32'h00000022, 32'h0000ABCD, 32'h0,        32'h00000020, 4'b1100, 32'hABCDABCD, 32'h00000000, 2'b00};
        vt[4]  = '{1'b0, 2'b01, 1'b0, 32'h00000022, 32'h0,        32'hABCD0000, 32'h00000020, 4'b0000, 32'h0,        32'hFFFFABCD, 2'b00};
        vt[5]  = '{1'b0, 2'b10, 1'b0, 32'h00000006, 32'h0,        32'h11111111, 32'h0,        4'b0000, 32'h0,        32'h00000000, 2'b01};
        vt[6]  = '{1'b0, 2'b01, 1'b0, 32'h00000003, 32'h0,        32'h11111111, 32'h0,        4'b0000, 32'h0,        32'h00000000, 2'b01};
        vt[7]  = '{1'b0, 2'b11, 1'b0, 32'h00000001, 32'h0,        32'h11111111, 32'h0,        4'b0000, 32'h0,        32'h00000000, 2'b11};
        vt[8]  = '{1'b0, 2'b10, 1'b0, 32'h00001000, 32'h0,        32'h11111111, 32'h0,        4'b0000, 32'h0,        32'h00000000, 2'b10};
        vt[9]  = '{1'b0, 2'b10, 1'b0, 32'h00000FFC, 32'h0,        32'h12345678, 32'h00000FFC, 4'b0000, 32'h0,        32'h12345678, 2'b00};
        vt[10] = '{1'b1, 2'b00, 1'b0, 32'h00000005, 32'h123456A7, 32'h0,        32'h00000004, 4'b0010, 32'hA7A7A7A7, 32'h00000000, 2'b00};
        vt[11] = '{1'b0, 2'b01, 1'b1, 32'h00000000, 32'h0,        32'h12348001, 32'h00000000, 4'b0000, 32'h0,        32'h00008001, 2'b00};
        vt[12] = '{1'b0, 2'b00, 1'b0, 32'h00000001, 32'h0,        32'h00007F00, 32'h00000000, 4'b0000, 32'h0,        32'h0000007F, 2'b00};
        vt[13] = '{1'b1, 2'b01, 1'b0, 32'h00000001, 32'hFFFF0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h00000000, 2'b01};
        vt[14] = '{1'b1, 2'b10, 1'b0, 32'h20000000, 32'h01020304, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h00000000, 2'b10};
        vt[15] = '{1'b0, 2'b00, 1'b1, 32'h00001003, 32'h0,        32'h11111111, 32'h0,        4'b0000, 32'h0,        32'h00000000, 2'b10};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", {30'd0, bus.rsp_err}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_strobes", {27'd0, bus.mem_rd_strobe, bus.mem_wr_strobe}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 16; i++) issue(vt[i]);

        // Abort a load in WAIT: no response may follow.
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0; bus.req_valid = 1'b1; mrd_src = 32'h87654321;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort_issue_rd", {31'd0, bus.mem_rd_strobe}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_strobes", {27'd0, bus.mem_rd_strobe, bus.mem_wr_strobe}, 32'd0);
        chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("abort_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        issue('{1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0, 4'b0000, 32'h0, 32'hCAFEF00D, 2'b00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
